// File: rtl/posit_pkg.sv
// Shared definitions for the 8-bit posit operand sequencer and its pair FIFO.
package posit_pkg;
  localparam int unsigned POSIT_W    = 8;
  localparam logic [7:0]  POSIT_ZERO = 8'h00;
  localparam logic [7:0]  POSIT_NAR  = 8'h80;
  localparam int unsigned PAIR_W     = 2 * POSIT_W + 1;

  typedef enum logic {ST_ACCUM, ST_OUT} seq_state_t;
endpackage

// File: rtl/posit_pair_fifo.sv
// Synchronous FIFO of {last, a, b} operand pairs with a combinational head view.
module posit_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             do_push, do_pop;

  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A write at full is legal only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: rtl/posit_dot_sequencer.sv
// Buffers (a,b) posit pairs, feeds them to an external MAC and owns its accumulator;
// emits one dot-product result per s_last-delimited vector.
module posit_dot_sequencer
  import posit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [POSIT_W-1:0] s_a,
  input  logic [POSIT_W-1:0] s_b,
  input  logic               s_last,
  output logic [POSIT_W-1:0] mac_a,
  output logic [POSIT_W-1:0] mac_b,
  output logic [POSIT_W-1:0] mac_c,
  input  logic [POSIT_W-1:0] mac_res,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [POSIT_W-1:0] m_result,
  output logic [CNT_W-1:0]   m_count
);
  seq_state_t         state_q, state_d;
  logic [POSIT_W-1:0] acc_q, acc_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, mcnt_q, mcnt_d, cnt_inc;
  logic               mvalid_q, mvalid_d;
  logic               full, empty, push, pop, head_last;
  logic [PAIR_W-1:0]  head;

  assign s_ready = ~full;
  assign push    = s_valid & s_ready & ~clr;
  assign pop     = (state_q == ST_ACCUM) & ~empty & ~clr;

  posit_pair_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PAIR_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(clr),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({s_last, s_a, s_b}),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign {head_last, mac_a, mac_b} = head;
  assign mac_c    = acc_q;
  assign m_valid  = mvalid_q;
  assign m_result = res_q;
  assign m_count  = mcnt_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    mcnt_d   = mcnt_q;
    mvalid_d = mvalid_q;
    if (clr) begin
      state_d  = ST_ACCUM;
      acc_d    = POSIT_ZERO;
      cnt_d    = '0;
      mvalid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (!empty) begin
            acc_d = mac_res;
            cnt_d = cnt_inc;
            if (head_last) begin
              res_d    = mac_res;
              mcnt_d   = cnt_inc;
              mvalid_d = 1'b1;
              acc_d    = POSIT_ZERO;
              cnt_d    = '0;
              state_d  = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            mvalid_d = 1'b0;
            state_d  = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      acc_q    <= POSIT_ZERO;
      cnt_q    <= '0;
      res_q    <= POSIT_ZERO;
      mcnt_q   <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      mcnt_q   <= mcnt_d;
      mvalid_q <= mvalid_d;
    end
  end
endmodule

// File: tb/tb_posit_dot_sequencer.sv
// Bench for posit_dot_sequencer: behavioural posit8 (es=0) MAC drives mac_res, and a
// vector-level scoreboard predicts every dot-product result and count.
module tb_posit_dot_sequencer;
  import posit_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, clr, s_valid, s_ready, s_last, m_valid, m_ready;
  logic [7:0]       s_a, s_b, mac_a, mac_b, mac_c, mac_res, m_result;
  logic [CNT_W-1:0] m_count;
  logic             rand_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  posit_dot_sequencer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_last  (s_last),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_c   (mac_c),
    .mac_res (mac_res),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_result(m_result),
    .m_count (m_count)
  );

  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Posit8, es=0 decode: sign, regime run, terminator, fraction.
  function automatic real p2r(logic [7:0] x);
    logic [7:0] u;
    int  k, i;
    real f, sc;
    if (x == 8'h00) return 0.0;
    u = x[7] ? (8'd0 - x) : x;
    i = 6;
    if (u[6]) begin
      k = -1;
      while (i >= 0 && u[i]) begin k++; i--; end
    end else begin
      k = 0;
      while (i >= 0 && !u[i]) begin k--; i--; end
    end
    i--;
    f  = 1.0;
    sc = 0.5;
    while (i >= 0) begin
      if (u[i]) f = f + sc;
      sc = sc / 2.0;
      i--;
    end
    return (x[7] ? -1.0 : 1.0) * f * pow2(k);
  endfunction

  // Nearest nonzero posit (never rounds to zero or NaR), ties to the even code.
  function automatic logic [7:0] r2p(real t);
    logic [7:0] best;
    real bd, d;
    if (t == 0.0) return 8'h00;
    best = 8'h01;
    bd   = p2r(8'h01) - t;
    if (bd < 0.0) bd = -bd;
    for (int c = 2; c < 256; c++) begin
      if (c != 128) begin
        d = p2r(8'(c)) - t;
        if (d < 0.0) d = -d;
        if (d < bd || (d == bd && (c % 2) == 0)) begin
          bd   = d;
          best = 8'(c);
        end
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] mac_fn(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    if (a == POSIT_NAR || b == POSIT_NAR || c == POSIT_NAR) return POSIT_NAR;
    return r2p(p2r(a) * p2r(b) + p2r(c));
  endfunction

  assign mac_res = mac_fn(mac_a, mac_b, mac_c);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: accepted pairs fold into a per-vector expected result.
  logic [7:0]       exp_res[$];
  int               exp_cnt[$];
  logic [7:0]       sb_acc = 8'h00;
  int               sb_n   = 0;
  logic             hold   = 1'b0;
  logic [7:0]       hold_res;
  logic [CNT_W-1:0] hold_cnt;

  always @(negedge clk) begin
    if (rst || clr) begin
      exp_res.delete();
      exp_cnt.delete();
      sb_acc = 8'h00;
      sb_n   = 0;
      hold   = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_result", int'(m_result), int'(hold_res));
        chk("hold_count", int'(m_count), int'(hold_cnt));
      end
      if (s_valid && s_ready) begin
        sb_acc = mac_fn(s_a, s_b, sb_acc);
        sb_n++;
        if (s_last) begin
          exp_res.push_back(sb_acc);
          exp_cnt.push_back(sb_n > CNT_MAX ? CNT_MAX : sb_n);
          sb_acc = 8'h00;
          sb_n   = 0;
        end
      end
      if (m_valid && m_ready) begin
        if (exp_res.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0h expected none", m_result);
        end else begin
          chk("result", int'(m_result), int'(exp_res.pop_front()));
          chk("count", int'(m_count), exp_cnt.pop_front());
        end
      end
      hold     = m_valid && !m_ready;
      hold_res = m_result;
      hold_cnt = m_count;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got s_ready=0 expected 1 within 200 cycles");
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic chk_res, input int res, input int cnt);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, int'(m_valid), 1);
    if (chk_res) chk({nm, "_result"}, int'(m_result), res);
    chk({nm, "_count"}, int'(m_count), cnt);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
    m_ready = 1'b1; rand_rdy = 1'b0;

    // Hand-computed posit8 values pin the reference MAC: 1*1+0=1, +1=2, +2=3, NaR sticky.
    chk("model_1", int'(mac_fn(8'h40, 8'h40, 8'h00)), 8'h40);
    chk("model_2", int'(mac_fn(8'h40, 8'h40, 8'h40)), 8'h60);
    chk("model_3", int'(mac_fn(8'h40, 8'h40, 8'h60)), 8'h68);
    chk("model_nar", int'(mac_fn(8'h80, 8'h40, 8'h00)), 8'h80);

    repeat (3) @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_mac_c", int'(mac_c), 8'h00);
    chk("rst_m_result", int'(m_result), 8'h00);
    chk("rst_m_count", int'(m_count), 0);
    step();
    rst = 1'b0;
    step();

    // Single-element vector: valid exactly two cycles after the push.
    push(8'h40, 8'h40, 1'b1);
    @(negedge clk);
    chk("t1_lat_t1", int'(m_valid), 0);
    @(negedge clk);
    chk("t1_lat_t2", int'(m_valid), 1);
    chk("t1_result", int'(m_result), 8'h40);
    chk("t1_count", int'(m_count), 1);
    step();

    push(8'h40, 8'h40, 1'b0);
    push(8'h40, 8'h40, 1'b0);
    push(8'h40, 8'h40, 1'b1);
    expect_out("t2", 1'b1, 8'h68, 3);

    // Back-pressure: output held while the FIFO fills.
    m_ready = 1'b0;
    push(8'h40, 8'h40, 1'b1);
    expect_out("t3_first", 1'b1, 8'h40, 1);
    s_valid = 1'b1;
    s_last  = 1'b1;
    repeat (8) begin
      s_a = 8'($urandom);
      s_b = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("t3_full_s_ready", int'(s_ready), 0);
    chk("t3_held_valid", int'(m_valid), 1);
    chk("t3_held_result", int'(m_result), 8'h40);
    step();

    // Release while still offering pairs: full FIFO pops, push refused until room.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_a = 8'($urandom); s_b = 8'($urandom);
    @(negedge clk);
    chk("t6_s_ready_hs", int'(s_ready), 0);
    step();
    s_a = 8'($urandom); s_b = 8'($urandom);
    @(negedge clk);
    chk("t6_s_ready_pop", int'(s_ready), 0);
    repeat (6) begin
      step();
      s_a = 8'($urandom);
      s_b = 8'($urandom);
    end
    step();
    s_valid = 1'b0;
    repeat (40) step();
    chk("t3_drained", exp_res.size(), 0);

    push(8'h80, 8'h40, 1'b0);
    push(8'h40, 8'h40, 1'b1);
    expect_out("t4_nar", 1'b1, 8'h80, 2);
    push(8'h40, 8'h40, 1'b1);
    expect_out("t4_fresh", 1'b1, 8'h40, 1);

    // clr mid-vector, with a competing push in the same cycle.
    push(8'h40, 8'h40, 1'b0);
    push(8'h40, 8'h40, 1'b0);
    clr = 1'b1; s_valid = 1'b1; s_a = 8'h40; s_b = 8'h40; s_last = 1'b1;
    step();
    clr = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_m_valid", int'(m_valid), 0);
    chk("t5_clr_s_ready", int'(s_ready), 1);
    chk("t5_clr_mac_c", int'(mac_c), 8'h00);
    step();
    push(8'h40, 8'h40, 1'b1);
    expect_out("t5_clr_after", 1'b1, 8'h40, 1);

    // Async reset with a pending result and buffered pairs.
    m_ready = 1'b0;
    push(8'h40, 8'h40, 1'b1);
    push(8'h40, 8'h40, 1'b0);
    push(8'h40, 8'h40, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_m_valid", int'(m_valid), 0);
    chk("t5_rst_s_ready", int'(s_ready), 1);
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    step();
    push(8'h40, 8'h40, 1'b1);
    expect_out("t5_rst_after", 1'b1, 8'h40, 1);

    // Count saturation on a long vector.
    for (int i = 0; i < 259; i++) push(8'($urandom), 8'($urandom), 1'b0);
    push(8'($urandom), 8'($urandom), 1'b1);
    expect_out("sat", 1'b0, 0, CNT_MAX);

    // Random vectors with random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) step();
    end
    push(8'h40, 8'h40, 1'b1);
    rand_rdy = 1'b0;
    m_ready  = 1'b1;
    repeat (40) step();
    chk("rand_drained", exp_res.size(), 0);
    chk("rand_idle_valid", int'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
